// File: rtl/pip_mem_rv32.sv
`default_nettype none
// ============================================================================
// pip_mem_rv32 : RV32I memory stage (req/ack data bus, lane steering, load
// extension). Optional macro MEM_MISALIGN_TRAP_EN.            Rev 1.0
// ============================================================================
module pip_mem_rv32 #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iVALID,
  input  logic        iMEM,
  input  logic        iRW,
  input  logic        iILLEGAL,
  input  logic [31:0] iMEMADDR,
  input  logic [31:0] iMEMDATA,
  input  logic [31:0] iDregDATA,
  input  logic [4:0]  iDregADDR,
  input  logic [4:0]  iDecodedOP,
  output logic        oSTALL,
  output logic        oBUSREQ,
  output logic        oBUSWE,
  output logic [29:0] oBUSADDR,
  output logic [3:0]  oBUSBE,
  output logic [31:0] oBUSWDATA,
  input  logic        iBUSACK,
  input  logic [31:0] iBUSRDATA,
  output logic        oRETIRE,
  output logic        oWBEN,
  output logic [4:0]  oDregADDR,
  output logic [31:0] oDregDATA,
  output logic [1:0]  oEXC
);

  localparam int         c_CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [1:0] c_EXC_NONE = 2'b00;
  localparam logic [1:0] c_EXC_MIS  = 2'b01;
  localparam logic [1:0] c_EXC_TMO  = 2'b10;
  localparam logic [1:0] c_EXC_ILL  = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [4:0]           r_op, w_op_nxt;
  logic [1:0]           r_lo, w_lo_nxt;
  logic                 r_rw, w_rw_nxt;
  logic [4:0]           r_rd, w_rd_nxt;
  logic                 r_busreq, w_busreq_nxt;
  logic                 r_buswe, w_buswe_nxt;
  logic [29:0]          r_busaddr, w_busaddr_nxt;
  logic [3:0]           r_busbe, w_busbe_nxt;
  logic [31:0]          r_buswdata, w_buswdata_nxt;
  logic                 r_retire, w_retire_nxt;
  logic                 r_wben, w_wben_nxt;
  logic [1:0]           r_exc, w_exc_nxt;
  logic [4:0]           r_daddr, w_daddr_nxt;
  logic [31:0]          r_ddata, w_ddata_nxt;

  logic                 w_is_b, w_is_h, w_is_w;
  logic                 w_op_bad, w_illegal, w_trap, w_tmo;
  logic [1:0]           w_lo;
  logic [3:0]           w_be;
  logic [31:0]          w_wdata;
  logic [7:0]           w_ld_byte;
  logic [15:0]          w_ld_half;
  logic [31:0]          w_ld_data;

  // Width decode of the incoming op; stores may only name B/H/W.
  assign w_is_b    = iDecodedOP[0] | iDecodedOP[3];
  assign w_is_h    = iDecodedOP[1] | iDecodedOP[4];
  assign w_is_w    = iDecodedOP[2];
  assign w_op_bad  = !$onehot(iDecodedOP) || (!iRW && (iDecodedOP[4:3] != 2'b00));
  assign w_illegal = iILLEGAL | (iMEM & w_op_bad);

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misal;
  assign w_misal = (w_is_h & iMEMADDR[0]) | (w_is_w & (iMEMADDR[1:0] != 2'b00));
  assign w_trap  = w_misal;
`else
  assign w_trap  = 1'b0;
`endif

  // Low address bits after forcing natural alignment for the access width.
  always_comb begin
    w_lo = iMEMADDR[1:0];
    if (w_is_w)      w_lo = 2'b00;
    else if (w_is_h) w_lo = {iMEMADDR[1], 1'b0};
  end

  always_comb begin
    w_be    = 4'b0001 << w_lo;
    w_wdata = {4{iMEMDATA[7:0]}};
    if (w_is_w) begin
      w_be    = 4'b1111;
      w_wdata = iMEMDATA;
    end else if (w_is_h) begin
      w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{iMEMDATA[15:0]}};
    end else if (!w_is_b) begin
      w_be    = 4'b0000;
    end
  end

  assign w_ld_byte = iBUSRDATA[{r_lo, 3'b000} +: 8];
  assign w_ld_half = r_lo[1] ? iBUSRDATA[31:16] : iBUSRDATA[15:0];

  always_comb begin
    w_ld_data = iBUSRDATA;
    if (r_op[0])      w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
    else if (r_op[3]) w_ld_data = {24'd0, w_ld_byte};
    else if (r_op[1]) w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
    else if (r_op[4]) w_ld_data = {16'd0, w_ld_half};
  end

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_tmo     = (TIMEOUT_CYC != 0) && (w_cnt_inc == c_CNT_W'(TIMEOUT_CYC));

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_op_nxt       = r_op;
    w_lo_nxt       = r_lo;
    w_rw_nxt       = r_rw;
    w_rd_nxt       = r_rd;
    w_busreq_nxt   = r_busreq;
    w_buswe_nxt    = r_buswe;
    w_busaddr_nxt  = r_busaddr;
    w_busbe_nxt    = r_busbe;
    w_buswdata_nxt = r_buswdata;
    w_retire_nxt   = 1'b0;
    w_wben_nxt     = 1'b0;
    w_exc_nxt      = c_EXC_NONE;
    w_daddr_nxt    = r_daddr;
    w_ddata_nxt    = r_ddata;
    case (r_state)
      S_IDLE: begin
        if (iVALID) begin
          w_daddr_nxt = iDregADDR;
          if (w_illegal) begin
            w_retire_nxt = 1'b1;
            w_exc_nxt    = c_EXC_ILL;
          end else if (!iMEM) begin
            w_retire_nxt = 1'b1;
            w_wben_nxt   = (iDregADDR != 5'd0);
            w_ddata_nxt  = iDregDATA;
          end else if (w_trap) begin
            w_retire_nxt = 1'b1;
            w_exc_nxt    = c_EXC_MIS;
          end else begin
            w_state_nxt    = S_WAIT;
            w_cnt_nxt      = '0;
            w_op_nxt       = iDecodedOP;
            w_lo_nxt       = w_lo;
            w_rw_nxt       = iRW;
            w_rd_nxt       = iDregADDR;
            w_busreq_nxt   = 1'b1;
            w_buswe_nxt    = !iRW;
            w_busaddr_nxt  = iMEMADDR[31:2];
            w_busbe_nxt    = w_be;
            w_buswdata_nxt = w_wdata;
          end
        end
      end
      S_WAIT: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (iBUSACK || w_tmo) begin
          w_state_nxt  = S_IDLE;
          w_busreq_nxt = 1'b0;
          w_buswe_nxt  = 1'b0;
          w_busbe_nxt  = 4'b0000;
          w_retire_nxt = 1'b1;
          w_daddr_nxt  = r_rd;
          if (iBUSACK) begin
            w_wben_nxt = r_rw && (r_rd != 5'd0);
            if (r_rw) w_ddata_nxt = w_ld_data;
          end else begin
            w_exc_nxt  = c_EXC_TMO;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_lo       <= '0;
      r_rw       <= 1'b0;
      r_rd       <= '0;
      r_busreq   <= 1'b0;
      r_buswe    <= 1'b0;
      r_busaddr  <= '0;
      r_busbe    <= '0;
      r_buswdata <= '0;
      r_retire   <= 1'b0;
      r_wben     <= 1'b0;
      r_exc      <= '0;
      r_daddr    <= '0;
      r_ddata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_op       <= w_op_nxt;
      r_lo       <= w_lo_nxt;
      r_rw       <= w_rw_nxt;
      r_rd       <= w_rd_nxt;
      r_busreq   <= w_busreq_nxt;
      r_buswe    <= w_buswe_nxt;
      r_busaddr  <= w_busaddr_nxt;
      r_busbe    <= w_busbe_nxt;
      r_buswdata <= w_buswdata_nxt;
      r_retire   <= w_retire_nxt;
      r_wben     <= w_wben_nxt;
      r_exc      <= w_exc_nxt;
      r_daddr    <= w_daddr_nxt;
      r_ddata    <= w_ddata_nxt;
    end
  end

  assign oSTALL    = (r_state == S_WAIT);
  assign oBUSREQ   = r_busreq;
  assign oBUSWE    = r_buswe;
  assign oBUSADDR  = r_busaddr;
  assign oBUSBE    = r_busbe;
  assign oBUSWDATA = r_buswdata;
  assign oRETIRE   = r_retire;
  assign oWBEN     = r_wben;
  assign oDregADDR = r_daddr;
  assign oDregDATA = r_ddata;
  assign oEXC      = r_exc;

endmodule
`default_nettype wire
